// File: rtl/uart_rx_pkg.sv
// Shared constants for the UART receiver: FSM state encoding, legal oversampling
// ratios and the strobe-point helper used by the frame controller.
package uart_rx_pkg;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_START   = 3'd1;
   localparam logic [2:0] ST_DATA    = 3'd2;
   localparam logic [2:0] ST_PARITY  = 3'd3;
   localparam logic [2:0] ST_STOP    = 3'd4;
   localparam logic [2:0] ST_ERR_CHK = 3'd5;

   typedef enum logic [2:0] {
      IDLE    = ST_IDLE,
      START   = ST_START,
      DATA    = ST_DATA,
      PARITY  = ST_PARITY,
      STOP    = ST_STOP,
      ERR_CHK = ST_ERR_CHK
   } rx_state_e;

   localparam int PRESCALE_8  = 8;
   localparam int PRESCALE_16 = 16;
   localparam int PRESCALE_32 = 32;

   // Edge at which the sampler's 3-sample vote (P/2-1..P/2+1) has settled.
   function automatic int strobe_pt(input int p);
      return p / 2 + 2;
   endfunction

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// Oversample (edge) and bit counters for the UART receiver; both clear
// whenever the controller is not walking a frame.
module uart_rx_edge_bit_cnt #(
   parameter int PRESCALE_W = 6,
   parameter int BIT_W      = 4
) (
   input  logic                  clk_RX,
   input  logic                  rst,
   input  logic                  enable_i,
   input  logic [PRESCALE_W-1:0] prescale_i,
   input  logic                  bit_inc_en_i,
   output logic [PRESCALE_W-1:0] edge_cnt_o,
   output logic [BIT_W-1:0]      bit_cnt_o,
   output logic                  edge_last_o
);

   logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
   logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
   logic                  edge_last;

   assign edge_last = (edge_cnt_q == prescale_i - PRESCALE_W'(1));

   always_comb begin
      edge_cnt_d = edge_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      if (!enable_i) begin
         edge_cnt_d = '0;
         bit_cnt_d  = '0;
      end else begin
         edge_cnt_d = edge_last ? '0 : edge_cnt_q + PRESCALE_W'(1);
         if (bit_inc_en_i && edge_last)
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
      end
   end

   always_ff @(posedge clk_RX or negedge rst) begin
      if (!rst) begin
         edge_cnt_q <= '0;
         bit_cnt_q  <= '0;
      end else begin
         edge_cnt_q <= edge_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
      end
   end

   assign edge_cnt_o  = edge_cnt_q;
   assign bit_cnt_o   = bit_cnt_q;
   assign edge_last_o = edge_last;

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receive frame controller: detects the start edge, walks start/data/parity/stop
// bits and issues one-cycle checker strobes plus the frame-accepted pulse.
module uart_rx_fsm
   import uart_rx_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int PRESCALE_W = 6
) (
   input  logic                  clk_RX,
   input  logic                  rst,
   input  logic                  RX_IN,
   input  logic [PRESCALE_W-1:0] Prescale,
   input  logic                  PAR_EN,
   input  logic                  Strt_glitch,
   input  logic                  Par_err,
   input  logic                  Stp_err,
   output logic [PRESCALE_W-1:0] edge_cnt,
   output logic                  dat_samp_en,
   output logic                  strt_chk_en,
   output logic                  deser_en,
   output logic                  par_chk_en,
   output logic                  stp_chk_en,
   output logic                  data_valid,
   output logic                  busy
);

   localparam int BIT_W = $clog2(DATA_WIDTH + 1);

   rx_state_e             state_q, state_d;
   logic                  cnt_en, bit_inc_en, edge_last, strb_hit;
   logic [BIT_W-1:0]      bit_cnt;
   logic [PRESCALE_W-1:0] strb_pt;

   assign cnt_en     = (state_q == START) || (state_q == DATA) ||
                       (state_q == PARITY) || (state_q == STOP);
   assign bit_inc_en = (state_q == DATA);
   assign strb_pt    = PRESCALE_W'(strobe_pt(int'(Prescale)));
   assign strb_hit   = (edge_cnt == strb_pt);

   uart_rx_edge_bit_cnt #(
      .PRESCALE_W (PRESCALE_W),
      .BIT_W      (BIT_W)
   ) u_cnt (
      .clk_RX       (clk_RX),
      .rst          (rst),
      .enable_i     (cnt_en),
      .prescale_i   (Prescale),
      .bit_inc_en_i (bit_inc_en),
      .edge_cnt_o   (edge_cnt),
      .bit_cnt_o    (bit_cnt),
      .edge_last_o  (edge_last)
   );

   always_ff @(posedge clk_RX or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   // Checker results are only trusted at the last edge of each bit.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (!RX_IN) state_d = START;
         START:   if (edge_last) state_d = Strt_glitch ? IDLE : DATA;
         DATA:    if (edge_last && bit_cnt == BIT_W'(DATA_WIDTH - 1))
                     state_d = PAR_EN ? PARITY : STOP;
         PARITY:  if (edge_last) state_d = STOP;
         STOP:    if (edge_last) state_d = ERR_CHK;
         ERR_CHK: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy        = 1'b0;
      dat_samp_en = 1'b0;
      strt_chk_en = 1'b0;
      deser_en    = 1'b0;
      par_chk_en  = 1'b0;
      stp_chk_en  = 1'b0;
      data_valid  = 1'b0;
      if (state_q != IDLE) begin
         busy        = 1'b1;
         dat_samp_en = 1'b1;
      end
      case (state_q)
         START:   strt_chk_en = strb_hit;
         DATA:    deser_en    = strb_hit;
         PARITY:  par_chk_en  = strb_hit;
         STOP:    stp_chk_en  = strb_hit;
         ERR_CHK: data_valid  = !Stp_err && !(PAR_EN && Par_err);
         default: ;
      endcase
   end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed bench for uart_rx_fsm: drives serial frames plus checker results and
// checks strobe counts/positions, frame latency and reset behaviour.
module tb_uart_rx_fsm;

   logic       clk_RX = 1'b0;
   logic       rst = 1'b0;
   logic       RX_IN = 1'b1;
   logic [5:0] Prescale = 6'd8;
   logic       PAR_EN = 1'b1;
   logic       Strt_glitch = 1'b0;
   logic       Par_err = 1'b0;
   logic       Stp_err = 1'b0;
   logic [5:0] edge_cnt;
   logic       dat_samp_en, strt_chk_en, deser_en, par_chk_en, stp_chk_en;
   logic       data_valid, busy;

   uart_rx_fsm dut (
      .clk_RX      (clk_RX),
      .rst         (rst),
      .RX_IN       (RX_IN),
      .Prescale    (Prescale),
      .PAR_EN      (PAR_EN),
      .Strt_glitch (Strt_glitch),
      .Par_err     (Par_err),
      .Stp_err     (Stp_err),
      .edge_cnt    (edge_cnt),
      .dat_samp_en (dat_samp_en),
      .strt_chk_en (strt_chk_en),
      .deser_en    (deser_en),
      .par_chk_en  (par_chk_en),
      .stp_chk_en  (stp_chk_en),
      .data_valid  (data_valid),
      .busy        (busy)
   );

   always #5 clk_RX = ~clk_RX;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   always @(posedge clk_RX) cyc <= cyc + 1;

   // Monitor: strobe counts, strobe positions and key event cycles per frame.
   logic mon_clr = 1'b1;
   int   exp_m = 6;
   logic busy_d = 1'b0;
   int   n_strt, n_deser, n_par, n_stp, n_dv, pos_bad;
   int   start_cyc, end_cyc, dv_cyc, dv_prev;

   always @(negedge clk_RX) begin
      busy_d <= busy;
      if (mon_clr) begin
         n_strt <= 0; n_deser <= 0; n_par <= 0; n_stp <= 0; n_dv <= 0; pos_bad <= 0;
         start_cyc <= -1; end_cyc <= -1; dv_cyc <= -1; dv_prev <= -1;
      end else begin
         if (strt_chk_en) n_strt  <= n_strt + 1;
         if (deser_en)    n_deser <= n_deser + 1;
         if (par_chk_en)  n_par   <= n_par + 1;
         if (stp_chk_en)  n_stp   <= n_stp + 1;
         if ((strt_chk_en || deser_en || par_chk_en || stp_chk_en) && int'(edge_cnt) != exp_m)
            pos_bad <= pos_bad + 1;
         if (data_valid) begin
            n_dv    <= n_dv + 1;
            dv_prev <= dv_cyc;
            dv_cyc  <= cyc;
         end
         if (busy && !busy_d && start_cyc < 0) start_cyc <= cyc;
         if (!busy && busy_d) end_cyc <= cyc;
      end
   end

   task automatic chk(input string tag, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic clr_mon();
      @(negedge clk_RX); mon_clr = 1'b1;
      @(negedge clk_RX); mon_clr = 1'b0;
   endtask

   task automatic hold_bit(input logic b, input int p);
      RX_IN = b;
      repeat (p) @(posedge clk_RX);
      #1;
   endtask

   // Serial frame: start, data LSB first, optional parity, stop; line left idle.
   task automatic send_frame(input int p, input logic [7:0] d, input logic pe,
                             input logic pb, input logic sb);
      logic [7:0] dd;
      dd = d;
      @(posedge clk_RX); #1;
      hold_bit(1'b0, p);
      for (int i = 0; i < 8; i++) hold_bit(dd[i], p);
      if (pe) hold_bit(pb, p);
      hold_bit(sb, p);
      RX_IN = 1'b1;
   endtask

   function automatic int outs();
      return int'({edge_cnt, dat_samp_en, strt_chk_en, deser_en, par_chk_en,
                   stp_chk_en, data_valid, busy});
   endfunction

   initial begin
      // Reset state
      #2;
      chk("rst_outs", outs(), 0);
      repeat (3) @(posedge clk_RX);
      #1 rst = 1'b1;
      repeat (3) @(posedge clk_RX);
      #1 chk("idle_busy", int'(busy), 0);

      // T1a: reset pulse while idle
      #2 rst = 1'b0;
      #1 chk("rst_idle_outs", outs(), 0);
      @(posedge clk_RX); #1 rst = 1'b1;

      // T1b: reset in the middle of DATA
      Prescale = 6'd8; PAR_EN = 1'b1; exp_m = 6;
      clr_mon();
      @(posedge clk_RX); #1 RX_IN = 1'b0;
      repeat (30) @(posedge clk_RX);
      #1 chk("mid_busy", int'(busy), 1);
      #2 rst = 1'b0;
      #1 chk("rst_mid_outs", outs(), 0);
      RX_IN = 1'b1;
      @(posedge clk_RX); #1 rst = 1'b1;
      repeat (100) @(posedge clk_RX);
      #1 chk("rst_mid_dv", n_dv, 0);
      chk("rst_mid_idle", int'(busy), 0);

      // T1c / T2: P=8, parity, 0xA5 (parity 0)
      clr_mon();
      send_frame(8, 8'hA5, 1'b1, 1'b0, 1'b1);
      repeat (16) @(posedge clk_RX);
      #1;
      chk("t2_strt", n_strt, 1);
      chk("t2_deser", n_deser, 8);
      chk("t2_par", n_par, 1);
      chk("t2_stp", n_stp, 1);
      chk("t2_pos", pos_bad, 0);
      chk("t2_dv", n_dv, 1);
      chk("t2_lat", dv_cyc - start_cyc, 88);
      chk("t2_len", end_cyc - start_cyc, 89);

      // T3: start glitch
      clr_mon();
      Strt_glitch = 1'b1;
      @(posedge clk_RX); #1;
      hold_bit(1'b0, 2);
      RX_IN = 1'b1;
      repeat (20) @(posedge clk_RX);
      #1;
      chk("t3_strt", n_strt, 1);
      chk("t3_deser", n_deser, 0);
      chk("t3_dv", n_dv, 0);
      chk("t3_len", end_cyc - start_cyc, 8);
      Strt_glitch = 1'b0;

      // T4: P=16, parity error
      Prescale = 6'd16; exp_m = 10; Par_err = 1'b1;
      clr_mon();
      send_frame(16, 8'hA5, 1'b1, 1'b1, 1'b1);
      repeat (32) @(posedge clk_RX);
      #1;
      chk("t4_deser", n_deser, 8);
      chk("t4_par", n_par, 1);
      chk("t4_pos", pos_bad, 0);
      chk("t4_dv", n_dv, 0);
      chk("t4_len", end_cyc - start_cyc, 177);

      // T5: P=16, no parity, stale Par_err ignored
      PAR_EN = 1'b0;
      clr_mon();
      send_frame(16, 8'h5A, 1'b0, 1'b0, 1'b1);
      repeat (32) @(posedge clk_RX);
      #1;
      chk("t5_par", n_par, 0);
      chk("t5_stp", n_stp, 1);
      chk("t5_dv", n_dv, 1);
      chk("t5_lat", dv_cyc - start_cyc, 160);
      Par_err = 1'b0;

      // T6: P=32, two back-to-back frames with one idle bit between
      Prescale = 6'd32; exp_m = 18;
      clr_mon();
      send_frame(32, 8'h3C, 1'b0, 1'b0, 1'b1);
      hold_bit(1'b1, 32 - 1);
      send_frame(32, 8'h3C, 1'b0, 1'b0, 1'b1);
      repeat (64) @(posedge clk_RX);
      #1;
      chk("t6_dv", n_dv, 2);
      chk("t6_gap", dv_cyc - dv_prev, 352);
      chk("t6_deser", n_deser, 16);
      chk("t6_pos", pos_bad, 0);
      chk("t6_idle", int'(busy), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
